// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// Registered FIFO with flush: head is visible the cycle after the push that
// filled an empty queue. Pointers wrap naturally because DEPTH is a power of 2.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   valid,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Flush dominates; a pop of an empty queue is ignored.
  assign w_push = push && !flush;
  assign w_pop  = pop && (r_count != '0) && !flush;

  // Storage write: payload only, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid = (r_count != '0);
  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch stage: issues word fetches to a variable-latency memory,
// buffers returned words with their PC and hands {instr, pc, pc+4} to decode.
// Redirects flush the buffer; responses to requests already in flight are
// counted off in DRAIN so none of them reaches decode.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4,
  output logic            fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e        r_state;
  ifu_state_e        w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_resp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_kill;
  logic              r_fault;

  logic [XLEN-1:0]   w_fetch_pc_nxt;
  logic [XLEN-1:0]   w_resp_pc_nxt;
  logic [CW-1:0]     w_out_nxt;
  logic [CW-1:0]     w_kill_nxt;
  logic              w_fault_set;

  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_flush;
  logic              w_fifo_valid;
  logic [2*XLEN-1:0] w_fifo_head;
  logic [CW-1:0]     w_fifo_count;
  logic [XLEN-1:0]   w_head_pc;
  logic [XLEN-1:0]   w_head_instr;

  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_take;
  logic              w_redir_ok;
  logic              w_redir_bad;

  // A new fetch is allowed only while every in-flight word is guaranteed a FIFO slot.
  assign w_req_valid = (r_state == RUN) &&
                       (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CW+1)'(DEPTH));
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_rsp_take  = imem_rsp_valid && (r_state != BOOT);
  assign w_redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  // In-flight count after this cycle's request and response.
  assign w_out_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);

  // Next-state and datapath steering; redirect outranks push, pop and PC advance.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_resp_pc_nxt  = r_resp_pc;
    w_kill_nxt     = r_kill;
    w_fault_set    = 1'b0;
    w_fifo_push    = 1'b0;
    w_fifo_pop     = 1'b0;
    w_fifo_flush   = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (w_redir_bad) begin
          w_fifo_flush = 1'b1;
          w_fault_set  = 1'b1;
          w_state_nxt  = HALT;
        end else if (w_redir_ok) begin
          w_fifo_flush   = 1'b1;
          w_fetch_pc_nxt = redirect_target;
          w_resp_pc_nxt  = redirect_target;
          w_kill_nxt     = w_out_nxt;
          w_state_nxt    = (w_out_nxt != '0) ? DRAIN : RUN;
        end else begin
          if (w_req_fire) w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
          if (imem_rsp_valid) begin
            w_fifo_push   = 1'b1;
            w_resp_pc_nxt = r_resp_pc + XLEN'(4);
          end
          w_fifo_pop = w_fifo_valid && dec_ready;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid && (r_kill != '0)) w_kill_nxt = r_kill - 1'b1;
        if (w_redir_bad) begin
          w_fifo_flush = 1'b1;
          w_fault_set  = 1'b1;
          w_state_nxt  = HALT;
        end else begin
          if (w_redir_ok) begin
            w_fetch_pc_nxt = redirect_target;
            w_resp_pc_nxt  = redirect_target;
          end
          if (w_kill_nxt == '0) w_state_nxt = RUN;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
    endcase
  end

  // FSM state, fetch/response PCs, in-flight and kill counters, sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_kill        <= '0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_out_nxt;
      r_kill        <= w_kill_nxt;
      r_fault       <= r_fault | w_fault_set;
    end
  end

  ifu_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (w_fifo_flush),
    .push      (w_fifo_push),
    .push_data ({imem_rsp_data, r_resp_pc}),
    .pop       (w_fifo_pop),
    .valid     (w_fifo_valid),
    .head      (w_fifo_head),
    .count     (w_fifo_count)
  );

  assign w_head_instr = w_fifo_head[2*XLEN-1:XLEN];
  assign w_head_pc    = w_fifo_head[XLEN-1:0];

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = w_req_valid ? r_fetch_pc : '0;
  assign dec_valid      = w_fifo_valid;
  assign dec_instr      = w_fifo_valid ? w_head_instr : XLEN'(NOP_INSTR);
  assign dec_pc         = w_fifo_valid ? w_head_pc : '0;
  assign dec_pc_plus4   = w_fifo_valid ? (w_head_pc + XLEN'(4)) : '0;
  assign fetch_fault    = r_fault;

  // In-flight plus buffered words never exceed the FIFO capacity.
  assert property (@(posedge clk) disable iff (reset)
    (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) <= (CW+1)'(DEPTH)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: memory model with programmable latency, a
// program-order model of the fetch stream checked every cycle, and directed
// scenarios with literal expectations.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;
  int mem_lat = 0;
  int cyc = 0;

  logic [31:0] q_addr [$];
  int          q_due  [$];

  logic [31:0] exp_dec;
  logic [31:0] exp_req;
  logic        exp_fault;

  ifu_prefetch #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_pc_plus4    (dec_pc_plus4),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents are a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dec_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!dec_valid && n < budget) begin
      tick();
      n++;
    end
    if (!dec_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for dec_valid after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_req_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!imem_req_valid && n < budget) begin
      tick();
      n++;
    end
    if (!imem_req_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for imem_req_valid after %0d cycles", name, budget);
    end
  endtask

  // Instruction memory: in-order responses after mem_lat cycles; cleared on reset.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q_addr.delete();
        q_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          q_addr.push_back(imem_req_addr);
          q_due.push_back(cyc + mem_lat);
        end
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(q_addr[0]);
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
      end
    end
  end

  // Program-order model: decode must see consecutive PCs from the last
  // redirect target, and requests must walk the same address stream.
  initial begin
    exp_dec   = 32'h0;
    exp_req   = 32'h0;
    exp_fault = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_dec   = 32'h0;
        exp_req   = 32'h0;
        exp_fault = 1'b0;
      end else begin
        if (exp_fault) begin
          chk1("halt_dec_valid", dec_valid, 1'b0);
          chk1("halt_req_valid", imem_req_valid, 1'b0);
        end
        if (dec_valid) begin
          chk("dec_pc", dec_pc, exp_dec);
          chk("dec_instr", dec_instr, mem_word(exp_dec));
          chk("dec_pc_plus4", dec_pc_plus4, exp_dec + 32'd4);
        end else begin
          chk("idle_instr", dec_instr, 32'h0000_0013);
          chk("idle_pc", dec_pc, 32'h0);
          chk("idle_pc_plus4", dec_pc_plus4, 32'h0);
        end
        chk1("fetch_fault", fetch_fault, exp_fault);
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_req);
          exp_req = exp_req + 32'd4;
        end
        if (redirect_valid && !exp_fault) begin
          if (redirect_target[1:0] != 2'b00) begin
            exp_fault = 1'b1;
          end else begin
            exp_dec = redirect_target;
            exp_req = redirect_target;
          end
        end else if (dec_valid && dec_ready) begin
          exp_dec = exp_dec + 32'd4;
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    int nreq;
    int n;
    imem_req_ready  = 1'b1;
    dec_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    mem_lat         = 0;
    reset           = 1'b1;
    tick();
    tick();

    // Reset values, then one BOOT cycle, then streaming at one per cycle.
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk1("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_instr", dec_instr, 32'h0000_0013);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_pc_plus4", dec_pc_plus4, 32'h0);
    chk1("rst_fetch_fault", fetch_fault, 1'b0);
    reset = 1'b0;
    chk1("boot_no_req", imem_req_valid, 1'b0);
    tick();
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk1("t1_dec_valid0", dec_valid, 1'b1);
    chk("t1_dec_pc0", dec_pc, 32'h0);
    chk("t1_dec_instr0", dec_instr, 32'hC0DE_0000);
    chk("t1_req_addr4", imem_req_addr, 32'h4);
    tick();
    chk1("t1_dec_valid1", dec_valid, 1'b1);
    chk("t1_dec_pc4", dec_pc, 32'h4);
    tick();
    chk("t1_dec_pc8", dec_pc, 32'h8);
    chk("t1_dec_instr8", dec_instr, 32'hC0D6_0008);
    chk("t1_dec_pc_plus4", dec_pc_plus4, 32'hC);
    repeat (10) tick();
    chk1("t1_sustained", dec_valid, 1'b1);

    // Decode stalled: exactly DEPTH fetches, then resume in order.
    dec_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    nreq = 0;
    repeat (10) begin
      if (imem_req_valid && imem_req_ready) nreq++;
      tick();
    end
    chk("t2_req_count", 32'(nreq), 32'(DEPTH));
    chk1("t2_req_valid_low", imem_req_valid, 1'b0);
    chk("t2_head_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    wait_req_valid("t2_resume", 5);
    chk("t2_resume_addr", imem_req_addr, 32'h8);
    repeat (8) tick();

    // Two requests in flight when redirected: both responses discarded.
    mem_lat = 3;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk1("t3_two_outstanding", imem_req_valid, 1'b0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk1("t3_drain_no_req", imem_req_valid, 1'b0);
    chk1("t3_flushed", dec_valid, 1'b0);
    wait_dec_valid("t3_refill", 40);
    chk("t3_head_pc", dec_pc, 32'h0000_0100);
    chk("t3_head_instr", dec_instr, 32'hC1DE_0100);
    repeat (6) tick();

    // Redirect coinciding with a request handshake and a pop.
    mem_lat = 1;
    n = 0;
    while (!(dec_valid && imem_req_valid && imem_req_ready) && n < 30) begin
      tick();
      n++;
    end
    if (!(dec_valid && imem_req_valid && imem_req_ready)) begin
      checks++;
      failures++;
      $display("FAIL t4_setup timeout waiting for handshake with valid head");
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk1("t4_flushed", dec_valid, 1'b0);
    chk1("t4_drain_no_req", imem_req_valid, 1'b0);
    wait_dec_valid("t4_refill", 40);
    chk("t4_head_pc", dec_pc, 32'h0000_0200);
    chk("t4_head_instr", dec_instr, 32'hC2DE_0200);
    repeat (6) tick();

    // Misaligned redirect: sticky fault, no more fetches.
    mem_lat = 0;
    repeat (4) tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    chk1("t5_fault", fetch_fault, 1'b1);
    chk1("t5_dec_valid", dec_valid, 1'b0);
    nreq = 0;
    repeat (10) begin
      if (imem_req_valid) nreq++;
      tick();
    end
    chk("t5_no_requests", 32'(nreq), 32'h0);
    chk1("t5_fault_sticky", fetch_fault, 1'b1);

    // Reset while draining: restart at RESET_PC, stale words never pushed.
    mem_lat = 3;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    chk1("t6_in_drain", imem_req_valid, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk1("t6_fault_cleared", fetch_fault, 1'b0);
    wait_req_valid("t6_restart", 5);
    chk("t6_restart_addr", imem_req_addr, 32'h0);
    wait_dec_valid("t6_refill", 20);
    chk("t6_head_pc", dec_pc, 32'h0);
    chk("t6_head_instr", dec_instr, 32'hC0DE_0000);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
